// File: rtl/axi4_burst_splitter.sv
// Splits a DMA request (start address, byte count) into AXI4 INCR burst commands.
// Each burst is capped by the remaining beats, MAX_BEATS and the next 4 KB boundary.
module axi4_burst_splitter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BYTES_W   = 24,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BYTES_W-1:0] req_bytes,
  output logic              ax_valid,
  input  logic              ax_ready,
  output logic [ADDR_W-1:0] ax_addr,
  output logic [7:0]        ax_len,
  output logic [2:0]        ax_size,
  output logic [1:0]        ax_burst,
  output logic              ax_last,
  output logic              busy
);

  localparam int unsigned BeatB     = DATA_W / 8;
  localparam int unsigned SizeW     = $clog2(BeatB);
  localparam int unsigned RemW      = BYTES_W - SizeW;
  localparam int unsigned PageBeats = 4096 / BeatB;
  // Common width for comparing remaining beats against the page/MAX_BEATS cap.
  localparam int unsigned CmpW      = (RemW > 13) ? RemW : 13;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [RemW-1:0]   req_beats;
  logic [11:0]       page_off;
  logic [CmpW-1:0]   rem_ext, page_room, cap, burst;

  assign ax_size   = 3'(SizeW);
  assign ax_burst  = 2'b01;
  // Sub-beat bits of the byte count are dropped.
  assign req_beats = RemW'(req_bytes >> SizeW);

  // Size of the burst that would be issued from the current address.
  always_comb begin
    page_off  = addr_q[11:0];
    page_room = CmpW'(PageBeats) - CmpW'(page_off >> SizeW);
    cap       = (page_room < CmpW'(MAX_BEATS)) ? page_room : CmpW'(MAX_BEATS);
    rem_ext   = CmpW'(rem_q);
    burst     = (rem_ext < cap) ? rem_ext : cap;
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    ax_valid  = 1'b0;
    ax_addr   = '0;
    ax_len    = '0;
    ax_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        // A zero-beat request is accepted and silently dropped.
        if (req_valid && (req_beats != '0)) begin
          addr_d  = req_addr & ~ADDR_W'(BeatB - 1);
          rem_d   = req_beats;
          state_d = StBurst;
        end
      end
      StBurst: begin
        busy     = 1'b1;
        ax_valid = 1'b1;
        ax_addr  = addr_q;
        ax_len   = 8'(burst - CmpW'(1));
        ax_last  = (rem_ext == burst);
        if (ax_ready) begin
          addr_d = addr_q + (ADDR_W'(burst) << SizeW);
          rem_d  = rem_q - RemW'(burst);
          if (ax_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

endmodule
